// File: rtl/wb_xactor_arbiter.sv
// Round-robin arbiter sharing one pipelined Wishbone master transactor between NUM_REQ clients,
// with an in-order tag FIFO steering responses back. Define WB_ARB_FIXED_PRIORITY_EN for lowest-index-wins.
module wb_xactor_arbiter #(
  parameter int NUM_REQ         = 2,
  parameter int MAX_OUTSTANDING = 8,
  parameter int IDW             = $clog2(NUM_REQ)
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic [NUM_REQ*69-1:0]  req_data,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [31:0]            rsp_data,
  output logic [NUM_REQ-1:0]     rsp_valid,
  input  logic [NUM_REQ-1:0]     rsp_ready,
  output logic [68:0]            xreq_data,
  output logic                   xreq_en,
  input  logic                   xreq_rdy,
  input  logic [31:0]            xrsp_data,
  input  logic                   xrsp_rdy,
  output logic                   xrsp_en
);

  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count;
  logic [IDW-1:0] tags [MAX_OUTSTANDING];
  logic [IDW-1:0] grant;
  logic [IDW-1:0] head;
  logic           found;
  logic           push, pop, nonempty;

`ifndef WB_ARB_FIXED_PRIORITY_EN
  logic [IDW-1:0] rr_ptr;
`endif

  // Grant search: first valid client at or after the search origin, wrapping
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    grant = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
`ifdef WB_ARB_FIXED_PRIORITY_EN
      idx = k;
`else
      idx = (int'(rr_ptr) + k) % NUM_REQ;
`endif
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        grant = IDW'(idx);
      end
    end
  end

  assign push      = RST_N && found && xreq_rdy && (count < CW'(MAX_OUTSTANDING));
  assign xreq_en   = push;
  assign req_ready = push ? (NUM_REQ'(1) << grant) : '0;
  assign xreq_data = req_data[69*int'(grant) +: 69];

  assign nonempty  = (count != '0);
  assign head      = tags[rd_ptr];
  assign rsp_valid = (RST_N && xrsp_rdy && nonempty) ? (NUM_REQ'(1) << head) : '0;
  assign rsp_data  = xrsp_data;
  assign pop       = |(rsp_valid & rsp_ready);
  assign xrsp_en   = pop;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
`ifndef WB_ARB_FIXED_PRIORITY_EN
      rr_ptr <= '0;
`endif
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == PW'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr + 1'b1;
`ifndef WB_ARB_FIXED_PRIORITY_EN
        rr_ptr <= (int'(grant) == NUM_REQ - 1) ? '0 : grant + 1'b1;
`endif
      end
      if (pop)
        rd_ptr <= (rd_ptr == PW'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Tag storage carries no reset; occupancy is tracked by count alone
  always_ff @(posedge CLK) begin
    if (push)
      tags[wr_ptr] <= grant;
  end

endmodule

// File: tb/tb_wb_xactor_arbiter.sv
// Randomized self-checking bench for wb_xactor_arbiter against a queue-based reference model.
module tb_wb_xactor_arbiter;

  localparam int NREQ = 3;
  localparam int MAXO = 8;

  logic                  CLK = 1'b0;
  logic                  RST_N;
  logic [NREQ*69-1:0]    req_data;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [31:0]           rsp_data;
  logic [NREQ-1:0]       rsp_valid;
  logic [NREQ-1:0]       rsp_ready;
  logic [68:0]           xreq_data;
  logic                  xreq_en;
  logic                  xreq_rdy;
  logic [31:0]           xrsp_data;
  logic                  xrsp_rdy;
  logic                  xrsp_en;

  int n_vec  = 0;
  int n_fail = 0;
  int q[$];
  int mptr = 0;

  wb_xactor_arbiter #(.NUM_REQ(NREQ), .MAX_OUTSTANDING(MAXO)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .req_data(req_data), .req_valid(req_valid), .req_ready(req_ready),
    .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .xreq_data(xreq_data), .xreq_en(xreq_en), .xreq_rdy(xreq_rdy),
    .xrsp_data(xrsp_data), .xrsp_rdy(xrsp_rdy), .xrsp_en(xrsp_en)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [68:0] got, input logic [68:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // One clock: predict from spec rules, compare, then advance the model on the edge
  task automatic cycle();
    int win, best, d;
    logic e_issue, e_pop;
    logic [NREQ-1:0] e_rdy, e_rv;
    win  = -1;
    best = NREQ;
    for (int i = 0; i < NREQ; i++) begin
      d = (i - mptr + NREQ) % NREQ;
      if (req_valid[i] && d < best) begin
        best = d;
        win  = i;
      end
    end
    e_issue = (win >= 0) && xreq_rdy && (q.size() < MAXO);
    e_rdy   = e_issue ? (NREQ'(1) << win) : '0;
    e_rv    = (xrsp_rdy && q.size() > 0) ? (NREQ'(1) << q[0]) : '0;
    e_pop   = (q.size() > 0) && xrsp_rdy && rsp_ready[q[0]];
    #1;
    chk("req_ready", 69'(req_ready), 69'(e_rdy));
    chk("xreq_en",   69'(xreq_en),   69'(e_issue));
    if (e_issue) chk("xreq_data", xreq_data, req_data[69*win +: 69]);
    chk("rsp_valid", 69'(rsp_valid), 69'(e_rv));
    chk("xrsp_en",   69'(xrsp_en),   69'(e_pop));
    if (e_rv != '0) chk("rsp_data", 69'(rsp_data), 69'(xrsp_data));
    @(posedge CLK);
    if (e_issue) begin
      q.push_back(win);
      mptr = (win + 1) % NREQ;
    end
    if (e_pop) void'(q.pop_front());
    #1;
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    #1;
    chk("rst_req_ready", 69'(req_ready), 69'(0));
    chk("rst_rsp_valid", 69'(rsp_valid), 69'(0));
    chk("rst_xreq_en",   69'(xreq_en),   69'(0));
    chk("rst_xrsp_en",   69'(xrsp_en),   69'(0));
    q.delete();
    mptr = 0;
    @(negedge CLK);
    RST_N = 1'b1;
    #1;
  endtask

  task automatic rand_data();
    for (int i = 0; i < NREQ; i++)
      req_data[69*i +: 69] = {1'($urandom), 4'($urandom), $urandom, $urandom};
    xrsp_data = $urandom;
  endtask

  task automatic drive(input logic [NREQ-1:0] v, input logic xr, input logic rr, input logic [NREQ-1:0] rs);
    rand_data();
    req_valid = v;
    xreq_rdy  = xr;
    xrsp_rdy  = rr;
    rsp_ready = rs;
  endtask

  initial begin
    RST_N     = 1'b0;
    req_data  = '0;
    req_valid = '0;
    rsp_ready = '0;
    xreq_rdy  = 1'b0;
    xrsp_rdy  = 1'b0;
    xrsp_data = '0;
    #3;
    // Reset with every input active: outputs must still be quiet
    drive('1, 1'b1, 1'b1, '1);
    do_reset();

    // Single client write, then its response
    drive(3'b001, 1'b1, 1'b0, '0);
    req_data[68:0] = {1'b1, 4'hF, 32'h0000_0100, 32'hDEAD_BEEF};
    cycle();
    drive(3'b000, 1'b0, 1'b1, 3'b001);
    cycle();

    // Round-robin between clients 0 and 1, then in-order responses
    for (int i = 0; i < 4; i++) begin drive(3'b011, 1'b1, 1'b0, '0); cycle(); end
    for (int i = 0; i < 4; i++) begin drive(3'b000, 1'b0, 1'b1, '1); cycle(); end

    // Fill to capacity, blocked 9th request, one pop, then issue resumes
    for (int i = 0; i < MAXO; i++) begin drive(3'b111, 1'b1, 1'b0, '0); cycle(); end
    drive(3'b001, 1'b1, 1'b0, '0); cycle();
    drive(3'b001, 1'b1, 1'b1, '1); cycle();
    drive(3'b001, 1'b1, 1'b0, '0); cycle();
    for (int i = 0; i < MAXO; i++) begin drive(3'b000, 1'b0, 1'b1, '1); cycle(); end

    // Head-of-line: tags [1,0], only client 0 ready stalls, then both served
    drive(3'b010, 1'b1, 1'b0, '0); cycle();
    drive(3'b001, 1'b1, 1'b0, '0); cycle();
    for (int i = 0; i < 2; i++) begin drive(3'b000, 1'b0, 1'b1, 3'b001); cycle(); end
    for (int i = 0; i < 2; i++) begin drive(3'b000, 1'b0, 1'b1, 3'b011); cycle(); end

    // Simultaneous push and pop at depth 3
    for (int i = 0; i < 3; i++) begin drive(3'b111, 1'b1, 1'b0, '0); cycle(); end
    for (int i = 0; i < 4; i++) begin drive(3'b111, 1'b1, 1'b1, '1); cycle(); end

    // Mid-stream reset with outstanding tags
    drive('1, 1'b1, 1'b1, '1);
    do_reset();
    drive(3'b110, 1'b1, 1'b0, '0); cycle();

    // Randomized traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      drive(NREQ'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
            NREQ'($urandom | $urandom));
      if ($urandom_range(0, 499) == 0) do_reset();
      else cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_xactor_arbiter.md
Name: wb_xactor_arbiter

Overview:
Shares one Wishbone master transactor (32-bit data and address, 8-deep, pipelined) between NUM_REQ client request/response ports.
- Arbitrates client requests round-robin and forwards each winner to the transactor's request_put handshake.
- Records the winner's ID in an in-order tag FIFO.
- Routes each response from the transactor's response_get handshake back to the client at the FIFO head.
- Sits between CPU/DMA clients and the transactor.

Parameters:
NUM_REQ, 2, number of client ports (2..8)
MAX_OUTSTANDING, 8, tag FIFO depth; must not exceed the transactor's request depth
IDW, $clog2(NUM_REQ), width of the stored requester ID

Ports:
CLK  in  1  clock
RST_N  in  1  reset
req_data  in  NUM_REQ*69  per-client request, packed {we[68], sel[67:64], adr[63:32], dat[31:0]}; client i at bits [69*i +: 69]
req_valid  in  NUM_REQ  client i has a request
req_ready  out  NUM_REQ  client i's request accepted this cycle
rsp_data  out  32  response data, broadcast to all clients
rsp_valid  out  NUM_REQ  response valid for client i
rsp_ready  in  NUM_REQ  client i takes its response
xreq_data  out  69  to transactor request_put data
xreq_en  out  1  to EN_server_request_put
xreq_rdy  in  1  from RDY_server_request_put
xrsp_data  in  32  from server_response_get data
xrsp_rdy  in  1  from RDY_server_response_get
xrsp_en  out  1  to EN_server_response_get

Behaviour:
- Reset: RST_N asynchronous, active-low; clock CLK.
  - Reset clears the round-robin pointer (0), FIFO read/write pointers and count (0).
  - While RST_N is low, req_ready, rsp_valid, xreq_en and xrsp_en are all 0.
  - Reset mid-operation discards all tags. The transactor shares the same reset, so no stale responses return.
- Grant:
  - Combinational search of req_valid, starting at the pointer and wrapping modulo NUM_REQ.
  - The first set bit is the winner g.
- Issue condition: winner exists, xreq_rdy=1 and FIFO count < MAX_OUTSTANDING. When the issue condition holds:
  - xreq_en=1, xreq_data = req_data[g], req_ready=one-hot(g).
  - Push g into the FIFO.
  - Pointer <= (g+1) mod NUM_REQ.
- No issue: xreq_en=0, req_ready=0 and the pointer holds. FIFO full blocks every client, even with xreq_rdy=1.
- Issue latency is zero cycles, combinational from req_valid/xreq_rdy to xreq_en. There are no registered outputs on the request path.
- Response:
  - h = FIFO head.
  - rsp_valid[h] = xrsp_rdy && count>0; all other rsp_valid bits are 0.
  - rsp_data = xrsp_data.
  - xrsp_en = rsp_valid[h] && rsp_ready[h]. When xrsp_en=1, pop the FIFO.
- Ordering: responses are delivered strictly in issue order. A head client that is not ready blocks all later responses (head-of-line blocking, by design).
- Simultaneous push and pop: count is unchanged; the pointers advance independently and wrap at MAX_OUTSTANDING.
- Orphan response (xrsp_rdy=1 with count=0): xrsp_en stays 0. This is flagged as a protocol violation by the formal harness.
- Handshake invariants, asserted by the formal bench:
  - xreq_en implies xreq_rdy.
  - xrsp_en implies xrsp_rdy.
  - req_ready is one-hot-or-zero.
  - req_ready[i] implies req_valid[i].
  - count <= MAX_OUTSTANDING.
- Fairness: with all NUM_REQ clients continuously valid and no stall, each client is granted once every NUM_REQ issues.

Optional Feature:
WB_ARB_FIXED_PRIORITY_EN
- Defined: the grant search always starts at index 0 (lowest index wins) and the pointer register is removed. Starvation of high indices is permitted.
- Undefined: round-robin as specified above.
- All other behaviour is identical.

Test Plan:
- Single client: after reset, req_valid=01, req_data[0] = write, sel=F, adr=0x100, dat=0xDEADBEEF, xreq_rdy=1 -> xreq_en=1 that cycle, xreq_data equal to req_data[0], FIFO count=1. Then xrsp_rdy=1, rsp_ready=01 -> rsp_valid=01, xrsp_en=1, count=0.
- Round-robin: req_valid=11 held for 4 cycles, xreq_rdy=1 -> grant sequence 0,1,0,1. Responses return to rsp_valid 01,10,01,10 in that order.
- Full: 8 issues with no responses -> count=8. On the 9th cycle req_valid=01, xreq_rdy=1 -> req_ready=0, xreq_en=0. One pop -> the next cycle issues.
- Head-of-line: tags [1,0], xrsp_rdy=1, rsp_ready=01 -> rsp_valid=10, xrsp_en=0 and stalls. Then rsp_ready=11 -> client 1 is served first, then client 0.
- Simultaneous push and pop with count=3 -> count stays 3, data ordering preserved. Async reset asserted mid-stream -> all outputs 0 immediately, count=0 and pointer=0 after release.
- With WB_ARB_FIXED_PRIORITY_EN: req_valid=11 held for 3 cycles -> grants 0,0,0.
